efx_datasync_filt: RTL and testbench
====================================

# efx_datasync_filt

Multi-channel, parametrised input conditioner for asynchronous single-bit signals such as pushbuttons, PHY status pins and cross-domain flags. Each channel passes through a STAGE-deep metastability chain, an optional consecutive-sample glitch filter, and an edge detector. The block provides registered levels plus one-cycle rise/fall pulses in the `clk_i` domain. It is the general replacement for the plain flop-chain synchronizer wherever consumers need debounced levels or edge events.

## Interface
- STAGE, 2, synchronizer depth; legal values are ≥ 2.
- WIDTH, 1, number of independent channels.
- FILTER, 4, number of consecutive differing synchronized samples required to change `data_out`; legal values are ≥ 1.
- RST_VAL, {WIDTH{1'b0}}, per-channel reset level for the sync chain, `data_out` and the edge reference.
- clk_i  input  1  sole clock; all state is rising-edge triggered.
- rst_n  input  1  asynchronous, active-low reset; deassertion is synchronous to `clk_i` externally.
- data_in  input  WIDTH  asynchronous channel inputs.
- data_out  output  WIDTH  filtered, synchronized level.
- rise_o  output  WIDTH  1-cycle pulse when `data_out[i]` goes 0→1.
- fall_o  output  WIDTH  1-cycle pulse when `data_out[i]` goes 1→0.
- chg_o  output  1  registered OR of all `rise_o` and `fall_o` bits, delayed one cycle.

## Operation
- **Synchronizer chain**
  - Per channel: `sync[0] <= data_in`, then `sync[k] <= sync[k-1]`.
  - The chain flops carry the `async_reg` attribute.
  - `s = sync[STAGE-1]`.
- **Filter** (per channel, with a counter `cnt` of width $clog2(FILTER+1)):
  - If `s == data_out`: `cnt <= 0`.
  - Else if `cnt == FILTER-1`: `data_out <= s` and `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
  - Result: a level change at `s` shorter than FILTER cycles is rejected, and the counter restarts whenever `s` returns to `data_out`.
- **Edge pulses**
  - `rise_o[i]` and `fall_o[i]` are registered on the same edge that updates `data_out[i]`.
  - Each is high for exactly one cycle per transition.
  - `rise_o[i]` and `fall_o[i]` are never high together.
- **Channel independence:** channels share no state except `chg_o`. Simultaneous transitions on several channels give simultaneous pulses.
- **Counter range:** the counter never exceeds FILTER-1; no wrap-around is possible.
- **Reset (any time, including mid-filter)**
  - All sync flops and `data_out` take RST_VAL.
  - `cnt`, `rise_o`, `fall_o` and `chg_o` take 0.
  - The reset itself never produces a pulse.
  - After release, an input differing from RST_VAL propagates normally and does produce a pulse.

## Timing
- Latency from a stable `data_in` change to `data_out` and its pulse:
  - with the filter: STAGE+FILTER rising edges;
  - without the filter: STAGE+1 rising edges.
- `chg_o` lags the pulses by 1 cycle.
- **Minimum accepted pulse width at `data_in`:** FILTER cycles (with filter); shorter pulses may or may not pass, depending on sampling.
- Back-to-back legal toggles (each ≥ FILTER cycles) each produce one pulse; none are merged or lost.
- There is no combinational path from any input to any output.

## Configuration
- Macro: `EFX_DATASYNC_FILT_FILTER_EN`.
- **Defined:** the filter is compiled in as described above.
- **Undefined:**
  - the filter and counters are removed;
  - `data_out <= s` every cycle, with pulses derived from the same edge;
  - the FILTER parameter is ignored;
  - all other behaviour is unchanged.

## Test plan
- **Basic latency.** WIDTH=1, STAGE=2, FILTER=4, RST_VAL=0; raise `data_in` at edge 10 and hold.
  - `data_out`=1 and `rise_o`=1 after edge 16, only for that cycle.
  - `chg_o`=1 after edge 17.
- **Glitch rejection.** Same config; pulse `data_in` high for 3 cycles.
  - `data_out` stays 0; no `rise_o` or `fall_o`.
  - Repeat with a 4-cycle pulse: exactly one `rise_o` and one `fall_o`, 4 cycles apart.
- **Bounce.** Pattern 1,1,0,1,1,1,1 with FILTER=4.
  - The counter restarts at the 0.
  - `data_out` rises 4 cycles after the last restart; one `rise_o` only.
- **Multi-channel and RST_VAL.** WIDTH=8, RST_VAL=8'hA5; hold `data_in`=8'hA5 through reset, then drive 8'h5A.
  - No pulses out of reset.
  - `rise_o`=8'h5A and `fall_o`=8'hA5 on the same cycle; `data_out`=8'h5A.
- **Reset mid-operation.** Assert `rst_n`=0 while `cnt`=2 and again on a pulse cycle.
  - Outputs clear immediately, asynchronously.
  - After release with `data_in`=1: `rise_o` arrives after the full STAGE+FILTER latency.
- **Macro undefined.** STAGE=3; a single-cycle `data_in` pulse.
  - `data_out` pulses for 1 cycle after 4 edges.
  - `rise_o` and `fall_o` appear on consecutive cycles.

Source files
------------

// File: rtl/efx_datasync_filt.sv
// efx_datasync_filt: per-channel STAGE-deep synchronizer, glitch filter and edge pulses.
// Define EFX_DATASYNC_FILT_FILTER_EN to compile in the FILTER-sample consecutive filter.
module efx_datasync_filt #(
  parameter int unsigned      STAGE   = 2,
  parameter int unsigned      WIDTH   = 1,
  parameter int unsigned      FILTER  = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             chg_o
);

  (* async_reg = "true" *) logic [STAGE-1:0][WIDTH-1:0] sync_q;
  logic [STAGE-1:0][WIDTH-1:0] sync_d;
  logic [WIDTH-1:0]            s;
  logic [WIDTH-1:0]            data_q, data_d;
  logic [WIDTH-1:0]            rise_q, rise_d;
  logic [WIDTH-1:0]            fall_q, fall_d;
  logic                        chg_q, chg_d;

  always_comb begin
    sync_d = {sync_q[STAGE-2:0], data_in};
  end

  assign s = sync_q[STAGE-1];

  // NOTE: sequential state uses <= so every flop sees pre-edge values of its neighbours.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the chain is reset to RST_VAL, not left unknown, so reset never looks like an edge.
      sync_q <= {STAGE{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

`ifdef EFX_DATASYNC_FILT_FILTER_EN
  localparam int unsigned      CNT_W   = $clog2(FILTER + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER - 1);

  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: defaults first, so no path through the loop can leave a variable unassigned (latch).
    data_d = data_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] == data_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        data_d[i] = s[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cnt_chk
    a_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_n) cnt_q[g] <= CNT_MAX);
  end
`else
  always_comb begin
    data_d = s;
  end
`endif

  // Pulses are computed from the next level so they register on the same edge as data_out.
  always_comb begin
    rise_d = data_d & ~data_q;
    fall_d = ~data_d & data_q;
    chg_d  = |{rise_q, fall_q};
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= RST_VAL;
      rise_q <= '0;
      fall_q <= '0;
      chg_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      chg_q  <= chg_d;
    end
  end

  assign data_out = data_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign chg_o    = chg_q;

  a_param_legal: assert property (@(posedge clk_i) (STAGE >= 2) && (FILTER >= 1));
  a_edge_excl:   assert property (@(posedge clk_i) disable iff (!rst_n) (rise_q & fall_q) == '0);

endmodule

// File: tb/tb_efx_datasync_filt.sv
// Directed bench for efx_datasync_filt: three instances cover WIDTH=1, WIDTH=8 with RST_VAL,
// and STAGE=3 with FILTER=1; expectations follow whether the filter macro is defined.
module tb_efx_datasync_filt;

`ifdef EFX_DATASYNC_FILT_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  // Edges from the first sampling edge to data_out for STAGE=2, FILTER=4.
  localparam int LAT = FILT ? (2 + 4) : (2 + 1);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din_a, dout_a, rise_a, fall_a, chg_a;
  logic [7:0] din_b, dout_b, rise_b, fall_b;
  logic       chg_b;
  logic       din_c, dout_c, rise_c, fall_c, chg_c;

  always #5 clk = ~clk;

  efx_datasync_filt #(.STAGE(2), .WIDTH(1), .FILTER(4), .RST_VAL(1'b0)) u_a (
    .clk_i(clk), .rst_n(rst_n), .data_in(din_a),
    .data_out(dout_a), .rise_o(rise_a), .fall_o(fall_a), .chg_o(chg_a));

  efx_datasync_filt #(.STAGE(2), .WIDTH(8), .FILTER(4), .RST_VAL(8'hA5)) u_b (
    .clk_i(clk), .rst_n(rst_n), .data_in(din_b),
    .data_out(dout_b), .rise_o(rise_b), .fall_o(fall_b), .chg_o(chg_b));

  efx_datasync_filt #(.STAGE(3), .WIDTH(1), .FILTER(1), .RST_VAL(1'b0)) u_c (
    .clk_i(clk), .rst_n(rst_n), .data_in(din_c),
    .data_out(dout_c), .rise_o(rise_c), .fall_o(fall_c), .chg_o(chg_c));

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Results of the last run_a() call; indices count edges after the call started.
  int rise_n, fall_n, rise_first, fall_first, chg_first, overlap_n;

  // Drives pat[i] on u_a for cycle i (tail afterwards) and records pulse activity.
  // Must be entered 1 time unit after a rising edge.
  task automatic run_a(input logic [31:0] pat, input int plen, input logic tail, input int ncyc);
    rise_n = 0; fall_n = 0; overlap_n = 0;
    rise_first = -1; fall_first = -1; chg_first = -1;
    for (int i = 0; i < ncyc; i++) begin
      din_a = (i < plen) ? pat[i] : tail;
      @(posedge clk); #1;
      if (rise_a) begin rise_n++; if (rise_first < 0) rise_first = i + 1; end
      if (fall_a) begin fall_n++; if (fall_first < 0) fall_first = i + 1; end
      if (chg_a && chg_first < 0) chg_first = i + 1;
      if (rise_a && fall_a) overlap_n++;
    end
  endtask

  initial begin
    int pulses, idx, dout_hi;
    logic [7:0] rv, fv;

    rst_n = 1'b0;
    din_a = 1'b0;
    din_b = 8'hA5;
    din_c = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout_a", int'(dout_a), 0);
    check("rst_rise_a", int'(rise_a), 0);
    check("rst_fall_a", int'(fall_a), 0);
    check("rst_chg_a",  int'(chg_a),  0);
    check("rst_dout_b", int'(dout_b), 'hA5);
    check("rst_pulse_b", int'(rise_b | fall_b), 0);
    check("rst_dout_c", int'(dout_c), 0);
    rst_n = 1'b1;

    // RST_VAL held through reset gives no pulses; then every bit flips at once.
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rise_b != 8'h00 || fall_b != 8'h00 || chg_b) pulses++;
    end
    check("rstval_no_pulse", pulses, 0);
    din_b = 8'h5A;
    idx = -1; rv = '0; fv = '0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if ((rise_b | fall_b) != 8'h00 && idx < 0) begin idx = i; rv = rise_b; fv = fall_b; end
    end
    check("multi_edge_at",  idx, LAT);
    check("multi_rise_val", int'(rv), 'h5A);
    check("multi_fall_val", int'(fv), 'hA5);
    check("multi_dout",     int'(dout_b), 'h5A);

    // Basic latency: rise, then fall.
    run_a(32'h0, 0, 1'b1, 16);
    check("basic_rise_n",     rise_n, 1);
    check("basic_rise_at",    rise_first, LAT);
    check("basic_chg_at",     chg_first, LAT + 1);
    check("basic_rise_fall",  fall_n, 0);
    check("basic_dout",       int'(dout_a), 1);
    run_a(32'h0, 0, 1'b0, 16);
    check("basic_fall_n",     fall_n, 1);
    check("basic_fall_at",    fall_first, LAT);
    check("basic_fall_rise",  rise_n, 0);

    // Glitch of 3 cycles, then a legal 4-cycle pulse.
    run_a(32'h7, 3, 1'b0, 16);
    check("glitch3_rise_n",   rise_n, FILT ? 0 : 1);
    check("glitch3_fall_n",   fall_n, FILT ? 0 : 1);
    check("glitch3_fall_at",  fall_first, FILT ? -1 : 3 + LAT);
    check("glitch3_dout",     int'(dout_a), 0);
    run_a(32'hF, 4, 1'b0, 16);
    check("pulse4_rise_n",    rise_n, 1);
    check("pulse4_fall_n",    fall_n, 1);
    check("pulse4_rise_at",   rise_first, LAT);
    check("pulse4_gap",       fall_first - rise_first, 4);

    // Bounce 1,1,0,1,1,1,1 then hold high.
    run_a(32'h7B, 7, 1'b1, 16);
    check("bounce_rise_n",    rise_n, FILT ? 1 : 2);
    check("bounce_rise_at",   rise_first, FILT ? 3 + LAT : LAT);
    check("bounce_fall_n",    fall_n, FILT ? 0 : 1);
    check("bounce_overlap",   overlap_n, 0);
    run_a(32'h0, 0, 1'b0, 16);
    check("bounce_settle",    int'(dout_a), 0);

    // STAGE=3, FILTER=1: a one-cycle input pulse passes as a one-cycle level.
    idx = -1; pulses = -1; dout_hi = 0;
    for (int i = 0; i < 10; i++) begin
      din_c = (i == 0);
      @(posedge clk); #1;
      if (rise_c && idx < 0) idx = i + 1;
      if (fall_c && pulses < 0) pulses = i + 1;
      if (dout_c) dout_hi++;
    end
    check("stage3_rise_at",   idx, 4);
    check("stage3_fall_at",   pulses, 5);
    check("stage3_dout_len",  dout_hi, 1);

    // Reset on a pulse cycle clears outputs asynchronously.
    din_a = 1'b1;
    repeat (LAT) begin @(posedge clk); #1; end
    check("prerst_rise",      int'(rise_a), 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_pulse_dout",   int'(dout_a), 0);
    check("rst_pulse_rise",   int'(rise_a), 0);
    check("rst_pulse_chg",    int'(chg_a), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_a(32'h0, 0, 1'b1, 16);
    check("rel1_rise_at",     rise_first, LAT);
    check("rel1_fall_n",      fall_n, 0);

    // Reset while the filter counter is part-way (cnt=2) toward a falling change.
    din_a = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_dout",     int'(dout_a), 0);
    check("rst_mid_fall",     int'(fall_a), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_a(32'h0, 0, 1'b1, 16);
    check("rel2_rise_at",     rise_first, LAT);
    check("rel2_rise_n",      rise_n, 1);
    check("rel2_fall_n",      fall_n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
